note_scheduler: RTL and testbench
=================================

NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of voice slots (2..8).
REQ-002 Parameter BASE_ADDR, default 16'h0010, bus address of voice 0 Gate register.
REQ-003 Parameter VOICE_STRIDE, default 16'h0020, address distance between consecutive voices.
REQ-004 Clock  in  1  single system clock; all logic on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 NoteValid  in  1  note event request.
REQ-007 NoteReady  out  1  scheduler can accept an event.
REQ-008 NoteOn  in  1  1 = note-on, 0 = note-off.
REQ-009 NoteKey  in  7  key identifier used to match note-off to voice.
REQ-010 NoteIncr  in  24  phase increment for note-on.
REQ-011 BusAddress  out  16  register address of current bus write.
REQ-012 BusWriteData  out  8  byte being written.
REQ-013 BusReadWrite  out  1  1 while a write byte is presented.
REQ-014 BusClock  out  1  write strobe; the synth latches on its rising edge.
REQ-015 VoiceActive  out  NUM_VOICES  bit v = 1 while voice v holds a gated note.

Function
REQ-016 The event shall be accepted on the Clock edge where NoteValid && NoteReady; NoteKey, NoteOn and NoteIncr shall be registered at that edge.
REQ-017 NoteReady shall be 1 only in state IDLE.
REQ-018 States: IDLE -> ALLOC (one cycle) -> WRITE (one or more bytes) -> IDLE; a note-off with no matching voice shall go ALLOC -> IDLE with no bus traffic.
REQ-019 Each byte write shall take 2 cycles: cycle A: BusAddress/BusWriteData valid, BusReadWrite=1, BusClock=1; cycle B: same address/data, BusClock=0.
REQ-020 Voice v register addresses: Gate = BASE_ADDR+v*VOICE_STRIDE, Incr bytes = Gate+1 (bits 7:0), +2 (15:8), +3 (23:16).
REQ-021 Note-on with an active voice holding the same key: retrigger that voice: write Incr bytes LSB first, then Gate=8'h01 (4 bytes).
REQ-022 Note-on, else lowest-index inactive voice: same 4-byte sequence.
REQ-023 Note-on, all voices active: steal least-recently-allocated voice: Gate=8'h00, then Incr bytes, then Gate=8'h01 (5 bytes).
REQ-024 Note-off: lowest-index active voice with matching key: Gate=8'h00 (1 byte); VoiceActive bit cleared on the cycle-B edge of that byte.
REQ-025 VoiceActive bit shall set, and the voice key store update, on the cycle-B edge of the final Gate=8'h01 byte.
REQ-026 The allocated/retriggered voice shall become most-recent in the LRU order in the same edge as REQ-025.
REQ-027 Latency, free voice note-on: accept at edge 0, ALLOC cycle 1, bytes cycles 2..9, NoteReady=1 in cycle 10; steal: NoteReady=1 in cycle 12; matched note-off: cycle 4; unmatched: cycle 2.
REQ-028 Outside WRITE, BusReadWrite=0, BusClock=0, BusAddress=0, BusWriteData=0.
REQ-029 Incoming events while busy shall be held off by NoteReady=0, never dropped.

Reset
REQ-030 While Reset=0 all outputs shall be 0, state IDLE, key store 0, LRU order = voice index order (voice 0 oldest).
REQ-031 Reset asserted mid-write shall immediately force bus outputs to 0 and abandon the sequence; NoteReady=1 in the first cycle after release.

Structure
REQ-032 Shared package synth_bus_pkg shall hold the register offsets (GATE=0, INCR=1), gate values, bus address width, and the state enumeration.
REQ-033 LRU tracking shall be a sub-module note_lru (per-voice rank, touch input, oldest-index output).
REQ-034 Byte sequencing shall use a byte counter indexing a per-event write list; no per-byte states.

Verification
REQ-035 Note-on key 60, Incr 24'h0FFFFF after reset -> writes 0x11=FF,0x12=FF,0x13=0F,0x10=01; VoiceActive=4'b0001; NoteReady returns cycle 10.
REQ-036 Note-on keys 60,62,64,65 then key 67 -> fifth event steals voice 0: 0x10=00, Incr bytes, 0x10=01; voice 0 key=67.
REQ-037 Note-off key 62 with voices 0..3 active -> single write 0x30=00; VoiceActive=4'b1101.
REQ-038 Note-off key 99 (unmatched) -> no BusReadWrite pulse; NoteReady back after 2 cycles.
REQ-039 Note-on key 60 twice -> second event retriggers voice 0 at 0x10..0x13; VoiceActive unchanged 4'b0001.
REQ-040 Reset pulse during 3rd byte of a note-on -> bus outputs 0 asynchronously, VoiceActive=0, next event goes to voice 0.

Source files
------------

// File: rtl/synth_bus_pkg.sv
// Shared bus constants, scheduler state and write-list helpers
// for the synth voice register bus.
package synth_bus_pkg;

  localparam int BUS_AW = 16;

  localparam logic [1:0] REG_GATE = 2'd0;
  localparam logic [1:0] REG_INCR = 2'd1;

  localparam logic [7:0] GATE_ON  = 8'h01;
  localparam logic [7:0] GATE_OFF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_WRITE
  } state_e;

  typedef enum logic [1:0] {
    WM_ON,
    WM_STEAL,
    WM_OFF
  } wmode_e;

  typedef struct packed {
    logic [1:0] off;
    logic [7:0] dat;
  } wl_ent_t;

  function automatic logic [2:0] wl_len(
    input wmode_e m
  );
    logic [2:0] n;
    case (m)
      WM_STEAL: n = 3'd5;
      WM_OFF:   n = 3'd1;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  // A steal is the note-on list with a gate-off byte in front.
  function automatic wl_ent_t wl_entry(
    input wmode_e      m,
    input logic [23:0] incr,
    input logic [2:0]  idx
  );
    wl_ent_t    e;
    logic [2:0] j;
    e.off = REG_GATE;
    e.dat = GATE_OFF;
    j     = idx;
    if (m == WM_STEAL) j = idx - 3'd1;
    if (m == WM_OFF) return e;
    if (m == WM_STEAL && idx == 3'd0) return e;
    case (j)
      3'd0: begin
        e.off = REG_INCR;
        e.dat = incr[7:0];
      end
      3'd1: begin
        e.off = REG_INCR + 2'd1;
        e.dat = incr[15:8];
      end
      3'd2: begin
        e.off = REG_INCR + 2'd2;
        e.dat = incr[23:16];
      end
      default: begin
        e.off = REG_GATE;
        e.dat = GATE_ON;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/note_lru.sv
// Least-recently-allocated tracker: one rank per voice,
// rank 0 is the oldest, NUM_VOICES-1 the newest.
module note_lru #(
  parameter int NUM_VOICES = 4,
  parameter int VW         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          touch_i,
  input  logic [VW-1:0] touch_idx_i,
  output logic [VW-1:0] oldest_o
);

  logic [VW-1:0] rank_q [NUM_VOICES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank_q[v] <= VW'(v);
      end
    end else if (touch_i) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VW'(v) == touch_idx_i) begin
          rank_q[v] <= VW'(NUM_VOICES - 1);
        end else if (rank_q[v] > rank_q[touch_idx_i]) begin
          rank_q[v] <= rank_q[v] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_q[v] == '0) oldest_o = VW'(v);
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Note event scheduler: allocates synth voices and streams the
// per-event register write list onto a two-cycle strobed byte bus.
module note_scheduler
  import synth_bus_pkg::*;
#(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  NoteValid,
  output logic                  NoteReady,
  input  logic                  NoteOn,
  input  logic [6:0]            NoteKey,
  input  logic [23:0]           NoteIncr,
  output logic [BUS_AW-1:0]     BusAddress,
  output logic [7:0]            BusWriteData,
  output logic                  BusReadWrite,
  output logic                  BusClock,
  output logic [NUM_VOICES-1:0] VoiceActive
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_e              state_q;
  logic                on_q;
  logic [6:0]          key_q;
  logic [23:0]         incr_q;
  wmode_e              mode_q;
  logic [VW-1:0]       voice_q;
  logic [2:0]          idx_q;
  logic                phb_q;
  logic [BUS_AW-1:0]   addr_q;
  logic [7:0]          data_q;
  logic                rw_q;
  logic                bclk_q;
  logic [NUM_VOICES-1:0] active_q;
  logic [6:0]          keys_q [NUM_VOICES];

  logic          hit, fre, go_d, last, touch;
  logic [VW-1:0] hit_v, fre_v, oldest, voice_d;
  wmode_e        mode_d;
  wl_ent_t       ent_a, ent_n;

  function automatic logic [BUS_AW-1:0] bus_addr(
    input logic [VW-1:0] v,
    input logic [1:0]    off
  );
    return BASE_ADDR + BUS_AW'(v) * VOICE_STRIDE + BUS_AW'(off);
  endfunction

  note_lru #(
    .NUM_VOICES(NUM_VOICES),
    .VW        (VW)
  ) u_lru (
    .clk        (Clock),
    .rst_n      (Reset),
    .touch_i    (touch),
    .touch_idx_i(voice_q),
    .oldest_o   (oldest)
  );

  // Downward scans leave the lowest matching index.
  always_comb begin
    hit   = 1'b0;
    hit_v = '0;
    fre   = 1'b0;
    fre_v = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active_q[v] && keys_q[v] == key_q) begin
        hit   = 1'b1;
        hit_v = VW'(v);
      end
      if (!active_q[v]) begin
        fre   = 1'b1;
        fre_v = VW'(v);
      end
    end
  end

  always_comb begin
    go_d    = 1'b1;
    mode_d  = WM_ON;
    voice_d = hit_v;
    unique case (1'b1)
      (on_q && hit): begin
        mode_d  = WM_ON;
        voice_d = hit_v;
      end
      (on_q && !hit && fre): begin
        mode_d  = WM_ON;
        voice_d = fre_v;
      end
      (on_q && !hit && !fre): begin
        mode_d  = WM_STEAL;
        voice_d = oldest;
      end
      (!on_q && hit): begin
        mode_d  = WM_OFF;
        voice_d = hit_v;
      end
      default: go_d = 1'b0;
    endcase
  end

  always_comb begin
    ent_a = wl_entry(mode_d, incr_q, 3'd0);
    ent_n = wl_entry(mode_q, incr_q, idx_q + 3'd1);
    last  = (idx_q == wl_len(mode_q) - 3'd1);
    touch = (state_q == ST_WRITE) && phb_q && last
            && (mode_q != WM_OFF);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      on_q     <= 1'b0;
      key_q    <= '0;
      incr_q   <= '0;
      mode_q   <= WM_ON;
      voice_q  <= '0;
      idx_q    <= '0;
      phb_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rw_q     <= 1'b0;
      bclk_q   <= 1'b0;
      active_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) keys_q[v] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (NoteValid) begin
            on_q    <= NoteOn;
            key_q   <= NoteKey;
            incr_q  <= NoteIncr;
            state_q <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (go_d) begin
            mode_q  <= mode_d;
            voice_q <= voice_d;
            idx_q   <= '0;
            phb_q   <= 1'b0;
            addr_q  <= bus_addr(voice_d, ent_a.off);
            data_q  <= ent_a.dat;
            rw_q    <= 1'b1;
            bclk_q  <= 1'b1;
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!phb_q) begin
            bclk_q <= 1'b0;
            phb_q  <= 1'b1;
          end else if (last) begin
            if (mode_q == WM_OFF) begin
              active_q[voice_q] <= 1'b0;
            end else begin
              active_q[voice_q] <= 1'b1;
              keys_q[voice_q]   <= key_q;
            end
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            phb_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            idx_q  <= idx_q + 3'd1;
            phb_q  <= 1'b0;
            addr_q <= bus_addr(voice_q, ent_n.off);
            data_q <= ent_n.dat;
            bclk_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign NoteReady    = Reset && (state_q == ST_IDLE);
  assign BusAddress   = addr_q;
  assign BusWriteData = data_q;
  assign BusReadWrite = rw_q;
  assign BusClock     = bclk_q;
  assign VoiceActive  = active_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: stimulus pushes expected
// bus writes, a negedge monitor pops and compares them.
module tb_note_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        NoteValid = 1'b0;
  logic        NoteReady;
  logic        NoteOn = 1'b0;
  logic [6:0]  NoteKey = '0;
  logic [23:0] NoteIncr = '0;
  logic [15:0] BusAddress;
  logic [7:0]  BusWriteData;
  logic        BusReadWrite;
  logic        BusClock;
  logic [3:0]  VoiceActive;

  int checks = 0;
  int failures = 0;

  logic [23:0] sb_q [$];
  logic [23:0] last_wr = '0;

  note_scheduler #(
    .NUM_VOICES  (4),
    .BASE_ADDR   (16'h0010),
    .VOICE_STRIDE(16'h0020)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .NoteValid   (NoteValid),
    .NoteReady   (NoteReady),
    .NoteOn      (NoteOn),
    .NoteKey     (NoteKey),
    .NoteIncr    (NoteIncr),
    .BusAddress  (BusAddress),
    .BusWriteData(BusWriteData),
    .BusReadWrite(BusReadWrite),
    .BusClock    (BusClock),
    .VoiceActive (VoiceActive)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: cycle A pops, cycle B must hold, otherwise bus idle.
  always @(negedge Clock) begin
    if (Reset) begin
      if (BusReadWrite && BusClock) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL bus_unexpected got=%h exp=none",
                   {BusAddress, BusWriteData});
        end else begin
          last_wr = sb_q.pop_front();
          if ({BusAddress, BusWriteData} !== last_wr) begin
            failures++;
            $display("FAIL bus_write got=%h exp=%h",
                     {BusAddress, BusWriteData}, last_wr);
          end
        end
      end else if (BusReadWrite) begin
        checks++;
        if ({BusAddress, BusWriteData} !== last_wr) begin
          failures++;
          $display("FAIL bus_hold got=%h exp=%h",
                   {BusAddress, BusWriteData}, last_wr);
        end
      end else begin
        checks++;
        if ({BusClock, BusAddress, BusWriteData} !== 25'd0) begin
          failures++;
          $display("FAIL bus_idle got=%h exp=0",
                   {BusClock, BusAddress, BusWriteData});
        end
      end
    end
  end

  function automatic logic [15:0] ga(input int v);
    return 16'h0010 + 16'(v) * 16'h0020;
  endfunction

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic push_on(input int v, input logic [23:0] incr);
    push(ga(v) + 16'd1, incr[7:0]);
    push(ga(v) + 16'd2, incr[15:8]);
    push(ga(v) + 16'd3, incr[23:16]);
    push(ga(v), 8'h01);
  endtask

  task automatic push_steal(input int v, input logic [23:0] incr);
    push(ga(v), 8'h00);
    push_on(v, incr);
  endtask

  task automatic push_off(input int v);
    push(ga(v), 8'h00);
  endtask

  // Leaves the bench in the negedge of cycle 1 after acceptance.
  task automatic issue(input logic on, input logic [6:0] key,
                       input logic [23:0] incr);
    int n;
    @(negedge Clock);
    n = 0;
    while (!NoteReady && n < 50) begin
      @(negedge Clock);
      n++;
    end
    chk("ready_before_issue", NoteReady, 1'b1);
    NoteValid = 1'b1;
    NoteOn    = on;
    NoteKey   = key;
    NoteIncr  = incr;
    @(negedge Clock);
    NoteValid = 1'b0;
  endtask

  task automatic send(input logic on, input logic [6:0] key,
                      input logic [23:0] incr, input int lat,
                      input logic [3:0] va);
    int n;
    issue(on, key, incr);
    n = 1;
    while (!NoteReady && n < 60) begin
      @(negedge Clock);
      n++;
    end
    #1;
    chk("ready_latency", n, lat);
    chk("voice_active", VoiceActive, va);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready", NoteReady, 1'b0);
    chk("rst_rw", BusReadWrite, 1'b0);
    chk("rst_bclk", BusClock, 1'b0);
    chk("rst_addr", BusAddress, 16'h0);
    chk("rst_data", BusWriteData, 8'h0);
    chk("rst_va", VoiceActive, 4'b0000);
    Reset = 1'b1;
    #1;
    chk("ready_after_rst", NoteReady, 1'b1);

    push_on(0, 24'h0FFFFF);
    send(1'b1, 7'd60, 24'h0FFFFF, 10, 4'b0001);

    push_on(0, 24'h123456);
    send(1'b1, 7'd60, 24'h123456, 10, 4'b0001);

    push_on(1, 24'h010203);
    send(1'b1, 7'd62, 24'h010203, 10, 4'b0011);
    push_on(2, 24'h0A0B0C);
    send(1'b1, 7'd64, 24'h0A0B0C, 10, 4'b0111);
    push_on(3, 24'hFEDCBA);
    send(1'b1, 7'd65, 24'hFEDCBA, 10, 4'b1111);

    push_steal(0, 24'h112233);
    send(1'b1, 7'd67, 24'h112233, 12, 4'b1111);

    push_off(1);
    send(1'b0, 7'd62, 24'h0, 4, 4'b1101);

    send(1'b0, 7'd99, 24'h0, 2, 4'b1101);

    push_off(0);
    send(1'b0, 7'd67, 24'h0, 4, 4'b1100);

    push_on(0, 24'h000080);
    send(1'b1, 7'd80, 24'h000080, 10, 4'b1101);

    // Abort a note-on to voice 1 during its third byte.
    push_on(1, 24'hABCDEF);
    issue(1'b1, 7'd70, 24'hABCDEF);
    repeat (5) @(negedge Clock);
    #1;
    chk("abort_bytes_left", sb_q.size(), 1);
    chk("abort_rw_before", BusReadWrite, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_rw", BusReadWrite, 1'b0);
    chk("abort_bclk", BusClock, 1'b0);
    chk("abort_addr", BusAddress, 16'h0);
    chk("abort_data", BusWriteData, 8'h0);
    chk("abort_va", VoiceActive, 4'b0000);
    chk("abort_ready", NoteReady, 1'b0);
    sb_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("ready_after_abort", NoteReady, 1'b1);

    push_on(0, 24'h345678);
    send(1'b1, 7'd72, 24'h345678, 10, 4'b0001);

    repeat (3) @(negedge Clock);
    #1;
    chk("final_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
